rsa_job_arbiter: RTL

Round-robin scheduler that shares one `rsa_unit` modular-exponentiation core between `NREQ` requesters. It arbitrates job requests, latches the winner's operands, and sequences the core's reset and enable around each job. It waits for `eoc`, captures the result and returns it to the owning requester over a valid/ready handshake. It sits between the requester ports and the `rsa_unit` instance and is the only driver of the core's control and operand inputs.

---
 rtl/rsa_arb_pkg.sv | 15 +
 rtl/rr_pick.sv | 30 +++
 rtl/rsa_job_arbiter.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/rsa_arb_pkg.sv
// Shared state encoding and default parameters for the RSA job arbiter.
package rsa_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } rsa_arb_state_e;

  localparam int unsigned DEF_WIDTH          = 8;
  localparam int unsigned DEF_NREQ           = 2;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 4096;

endpackage

// File: rtl/rr_pick.sv
// Round-robin priority picker: first set request at or after ptr, with wrap-around.
module rr_pick #(
  parameter  int unsigned N  = 2,
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  int unsigned cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = 0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = (32'(ptr) + k) % N;
      if (!any && req[IW'(cand)]) begin
        any              = 1'b1;
        idx              = IW'(cand);
        grant[IW'(cand)] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rsa_job_arbiter.sv
// Round-robin scheduler sharing one rsa_unit core between NREQ requesters.
// Optional watchdog on the RUN phase: define RSA_ARB_TIMEOUT_EN.
module rsa_job_arbiter
  import rsa_arb_pkg::*;
#(
  parameter  int unsigned WIDTH          = DEF_WIDTH,
  parameter  int unsigned NREQ           = DEF_NREQ,
  parameter  int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  localparam int unsigned IW             = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_p,
  input  logic [NREQ*WIDTH-1:0] req_e,
  input  logic [NREQ*WIDTH-1:0] req_m,
  input  logic [NREQ*WIDTH-1:0] req_const,
  output logic [NREQ-1:0]       rsp_valid,
  input  logic [NREQ-1:0]       rsp_ready,
  output logic [WIDTH-1:0]      rsp_c,
  output logic                  rsp_err,
  output logic                  busy,
  output logic [IW-1:0]         owner,
  output logic                  rsa_rstb,
  output logic                  rsa_en,
  output logic [WIDTH-1:0]      rsa_p,
  output logic [WIDTH-1:0]      rsa_e,
  output logic [WIDTH-1:0]      rsa_m,
  output logic [WIDTH-1:0]      rsa_const,
  input  logic [WIDTH-1:0]      rsa_c,
  input  logic                  rsa_eoc
);

  if (NREQ < 2 || NREQ > 8 || TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("rsa_job_arbiter: NREQ must be 2..8 and TIMEOUT_CYCLES at least 2");
  end

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_LOAD = LOAD;
  localparam logic [1:0] S_RUN  = RUN;
  localparam logic [1:0] S_DONE = DONE;

  logic [1:0]      state, state_nxt;
  logic [IW-1:0]   rr_ptr;
  logic [NREQ-1:0] pick_grant;
  logic [IW-1:0]   pick_idx;
  logic            pick_any;
  logic            hs;
  logic            tmo_hit;
  logic            busy_nxt, rstb_nxt, en_nxt;
  logic [NREQ-1:0] rsp_valid_nxt;

  logic [WIDTH-1:0] p_arr [NREQ];
  logic [WIDTH-1:0] e_arr [NREQ];
  logic [WIDTH-1:0] m_arr [NREQ];
  logic [WIDTH-1:0] k_arr [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign p_arr[g] = req_p[g*WIDTH +: WIDTH];
    assign e_arr[g] = req_e[g*WIDTH +: WIDTH];
    assign m_arr[g] = req_m[g*WIDTH +: WIDTH];
    assign k_arr[g] = req_const[g*WIDTH +: WIDTH];
  end

  rr_pick #(.N(NREQ)) u_pick (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // Grant is only offered in IDLE; a granted valid is a handshake by construction.
  assign hs        = (state == S_IDLE) && pick_any && !rst;
  assign req_ready = hs ? pick_grant : '0;

`ifdef RSA_ARB_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
  logic [TW-1:0] run_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  run_cnt <= '0;
    else if (state == S_LOAD) run_cnt <= '0;
    else if (state == S_RUN)  run_cnt <= run_cnt + TW'(1);
  end

  // A same-cycle eoc takes priority over the watchdog.
  assign tmo_hit = (state == S_RUN) && !rsa_eoc && (run_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (hs) state_nxt = S_LOAD;
      S_LOAD:  state_nxt = S_RUN;
      S_RUN:   if (rsa_eoc || tmo_hit) state_nxt = S_DONE;
      S_DONE:  if (rsp_ready[owner]) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    busy_nxt      = (state_nxt != S_IDLE);
    rstb_nxt      = (state_nxt == S_RUN) || (state_nxt == S_DONE);
    en_nxt        = (state_nxt == S_RUN);
    rsp_valid_nxt = (state_nxt == S_DONE) ? (NREQ'(1) << owner) : '0;
  end

  // Core controls are registered so they leave reset and change glitch-free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy      <= 1'b0;
      rsa_rstb  <= 1'b0;
      rsa_en    <= 1'b0;
      rsp_valid <= '0;
    end else begin
      busy      <= busy_nxt;
      rsa_rstb  <= rstb_nxt;
      rsa_en    <= en_nxt;
      rsp_valid <= rsp_valid_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr    <= '0;
      owner     <= '0;
      rsa_p     <= '0;
      rsa_e     <= '0;
      rsa_m     <= '0;
      rsa_const <= '0;
      rsp_c     <= '0;
      rsp_err   <= 1'b0;
    end else begin
      if (hs) begin
        rsa_p     <= p_arr[pick_idx];
        rsa_e     <= e_arr[pick_idx];
        rsa_m     <= m_arr[pick_idx];
        rsa_const <= k_arr[pick_idx];
        owner     <= pick_idx;
        rr_ptr    <= (pick_idx == IW'(NREQ - 1)) ? '0 : pick_idx + IW'(1);
      end
      if ((state == S_RUN) && rsa_eoc) begin
        rsp_c   <= rsa_c;
        rsp_err <= 1'b0;
      end else if (tmo_hit) begin
        rsp_c   <= '0;
        rsp_err <= 1'b1;
      end
    end
  end

endmodule
